// File: rtl/shifter_sll_seq_pkg.sv
// Shared ALU definitions: operation codes and the sequential-shifter state encoding.
// Latency: none; this package holds declarations only.
// Backpressure: none.
package shifter_sll_seq_pkg;

  // ALU operation codes as driven on the Signal bus
  localparam logic [2:0] SRL = 3'b011;
  localparam logic [2:0] SLL = 3'b100;

  // Sequential shifter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shifter_sll_seq_stage.sv
// One power-of-two left-shift stage: dout = en ? din << (1 << k) : din.
// Latency: combinational.
// Backpressure: none.

// 1-bit 2:1 mux cell, shared with the right-shifter datapath
module mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module sll_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   k,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  // Candidate value if this stage is enabled; zeros fill from the LSB side
  logic [WIDTH-1:0] shifted;
  assign shifted = din << (32'd1 << k);

  // Per-bit select between pass-through and shifted value
  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    mux2 uMux (
      .a   (din[i]),
      .b   (shifted[i]),
      .sel (en),
      .y   (dout[i])
    );
  end

endmodule

// File: rtl/shifter_sll_seq.sv
// Multi-cycle logical-left shifter (SLL) for the EX stage, one power-of-two stage per clock.
// Latency: start sampled in cycle N -> busy N+1..N+6, done strobe and dataOut valid in N+6.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, not queued.
module shifter_sll_seq
  import shifter_sll_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [SHW-1:0]   dataB,
  input  logic [2:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] accNext;
  logic             stageEn;

  // Current stage is applied only when the matching shamt bit is set
  assign stageEn = |(sh & (SHW'(1) << cnt));

  sll_stage #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) uStage (
    .din  (acc),
    .k    (cnt),
    .en   (stageEn),
    .dout (accNext)
  );

  // Control FSM with registered busy/done and result hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      acc     <= '0;
      dataOut <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Non-SLL ops still run the full latency but shift a zero operand
            acc   <= (Signal == SLL) ? dataA : '0;
            sh    <= dataB;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= accNext;
          if (cnt == SHW'(SHW - 1)) begin
            dataOut <= accNext;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_sll_seq.sv
// Directed and random checks of the sequential SLL shifter: latency, handshake, results, reset.
// Latency: inputs driven and outputs sampled on the falling edge, away from the active edge.
// Backpressure: start held high exercises the accept-only-in-IDLE behaviour.
module tb_shifter_sll_seq;

  localparam logic [2:0] SLLOP = 3'b100;
  localparam logic [2:0] SRLOP = 3'b011;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dataA;
  logic [4:0]  dataB;
  logic [2:0]  sigOp;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int compared = 0;
  int mismatched = 0;

  shifter_sll_seq #(
    .WIDTH (32),
    .SHW   (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (sigOp),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [31:0] a, input logic [4:0] b,
                                           input logic [2:0] s);
    return (s == SLLOP) ? (a << b) : 32'h0;
  endfunction

  // Issue one op in the current (falling-edge) cycle and check busy/done/dataOut through N+7
  task automatic runOp(input string tag, input logic [31:0] a, input logic [4:0] b,
                       input logic [2:0] s, input logic [31:0] exp, input bit fullCheck);
    start = 1'b1; dataA = a; dataB = b; sigOp = s;
    @(negedge clk);
    start = 1'b0; dataA = $urandom; dataB = 5'($urandom); sigOp = 3'($urandom);
    for (int k = 1; k <= 6; k++) begin
      if (fullCheck) begin
        check({tag, " busy"}, {31'b0, busy}, 32'd1);
        check({tag, " done"}, {31'b0, done}, (k == 6) ? 32'd1 : 32'd0);
      end
      if (k == 6) check({tag, " dataOut"}, dataOut, exp);
      @(negedge clk);
    end
    if (fullCheck) begin
      check({tag, " idle busy"}, {31'b0, busy}, 32'd0);
      check({tag, " idle done"}, {31'b0, done}, 32'd0);
      check({tag, " held dataOut"}, dataOut, exp);
    end
  endtask

  logic [31:0] opA [3];
  logic [4:0]  opB [3];
  logic [2:0]  opS [3];

  initial begin
    rst_n = 1'b0; start = 1'b0; dataA = '0; dataB = '0; sigOp = '0;
    #2;
    check("reset dataOut", dataOut, 32'h0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    runOp("msb", 32'h0000_0001, 5'd31, SLLOP, 32'h8000_0000, 1'b1);
    runOp("deadbeef", 32'hDEAD_BEEF, 5'd4, SLLOP, 32'hEADB_EEF0, 1'b1);
    runOp("shamt0", 32'h1234_5678, 5'd0, SLLOP, 32'h1234_5678, 1'b1);
    runOp("shamt17", 32'hFFFF_FFFF, 5'd17, SLLOP, 32'hFFFE_0000, 1'b1);
    runOp("srl zero", 32'hFFFF_FFFF, 5'd3, SRLOP, 32'h0, 1'b1);
    runOp("pre reset", 32'hA5A5_A5A5, 5'd1, SLLOP, 32'h4B4B_4B4A, 1'b1);

    // Asynchronous reset mid-SHIFT, asserted between edges
    start = 1'b1; dataA = 32'h0F0F_0F0F; dataB = 5'd2; sigOp = SLLOP;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst dataOut", dataOut, 32'h0);
    check("async rst busy", {31'b0, busy}, 32'd0);
    check("async rst done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int doneSeen = 0;
      for (int k = 0; k < 8; k++) begin
        if (done) doneSeen++;
        @(negedge clk);
      end
      check("no done after abort", 32'(doneSeen), 32'd0);
    end
    runOp("post reset", 32'h0000_00FF, 5'd8, SLLOP, 32'h0000_FF00, 1'b1);

    // start held high: accepts only at c = 0, 7, 14
    opA[0] = 32'h1111_1111; opB[0] = 5'd1;  opS[0] = SLLOP;
    opA[1] = 32'h8000_0001; opB[1] = 5'd31; opS[1] = SLLOP;
    opA[2] = 32'hCAFE_F00D; opB[2] = 5'd16; opS[2] = SLLOP;
    start = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c % 7 == 0) begin
        dataA = opA[c/7]; dataB = opB[c/7]; sigOp = opS[c/7];
      end else begin
        dataA = $urandom; dataB = 5'($urandom); sigOp = (c % 2 == 0) ? SLLOP : 3'($urandom);
      end
      if (c >= 1) begin
        check("hold busy", {31'b0, busy}, (c % 7 != 0) ? 32'd1 : 32'd0);
        check("hold done", {31'b0, done}, (c % 7 == 6) ? 32'd1 : 32'd0);
      end
      if (c >= 6) check("hold dataOut", dataOut,
                        refModel(opA[(c-6)/7], opB[(c-6)/7], opS[(c-6)/7]));
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge clk);

    // Random regression
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a;
      logic [4:0]  b;
      logic [2:0]  s;
      a = $urandom;
      b = 5'($urandom);
      s = ($urandom_range(0, 1) == 1) ? SLLOP : 3'($urandom_range(0, 7));
      runOp("random", a, b, s, refModel(a, b, s), 1'b0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
